// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package rv_fetch_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Program storage: one synchronous read port, one write port, read-before-write.
module imem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rd_en,
  input  logic [AW-1:0]                    rd_addr,
  output logic [rv_fetch_pkg::WORD_W-1:0]  rd_data,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [rv_fetch_pkg::WORD_W-1:0]  wr_data
);

  logic [rv_fetch_pkg::WORD_W-1:0] mem [DEPTH];

  // Contents survive reset so a loaded program is kept across a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: accepts a word-addressed fetch, answers after WAIT_CYCLES
// wait states, with a side program-load port and a redirect flush.
module instr_mem_responder #(
  parameter int unsigned                      DEPTH       = 256,
  parameter int unsigned                      WAIT_CYCLES = 1,
  parameter logic [rv_fetch_pkg::WORD_W-1:0]  NOP_INSTR   = rv_fetch_pkg::NOP_INSTR
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [rv_fetch_pkg::WORD_W-1:0]  req_addr,
  input  logic                             flush,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [rv_fetch_pkg::WORD_W-1:0]  rsp_instr,
  output logic [rv_fetch_pkg::WORD_W-1:0]  rsp_addr,
  output logic                             rsp_fault,
  input  logic                             load_en,
  input  logic [rv_fetch_pkg::WORD_W-1:0]  load_addr,
  input  logic [rv_fetch_pkg::WORD_W-1:0]  load_data,
  output logic                             busy
);

  import rv_fetch_pkg::*;

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] fetch_addr;
  logic [WORD_W-1:0] rd_word;
  logic              fault_q;
  logic              accept;
  logic              rd_en;
  logic              wr_en;
  logic              unused_load_hi;

  assign req_ready  = (state_q == IDLE) & ~flush & ~load_en & reset;
  assign accept     = req_valid & req_ready;
  // Zero-wait fetches read straight from the request bus on the accept edge.
  assign fetch_addr = (state_q == IDLE) ? req_addr : addr_q;

  // Load address is indexed by its low bits only.
  assign wr_en          = load_en & (WORD_W'(load_addr[AW-1:0]) < WORD_W'(DEPTH));
  assign unused_load_hi = ^load_addr[WORD_W-1:AW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) addr_q  <= req_addr;
      if (rd_en)  fault_q <= (fetch_addr >= WORD_W'(DEPTH));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .rd_en   (rd_en),
    .rd_addr (fetch_addr[AW-1:0]),
    .rd_data (rd_word),
    .wr_en   (wr_en),
    .wr_addr (load_addr[AW-1:0]),
    .wr_data (load_data)
  );

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_addr  = addr_q;
  assign rsp_fault = fault_q;
  assign rsp_instr = fault_q ? NOP_INSTR : rd_word;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized + directed bench for instr_mem_responder with a transaction-level model and scoreboard.
module tb_instr_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, flush;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_fault, busy;
  logic [31:0] rsp_instr, rsp_addr;
  logic        load_en;
  logic [31:0] load_addr, load_data;

  instr_mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITC),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
    int          vcyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_phase = 0;   // 0 no fetch, 1 waiting for data, 2 response presented
  int          m_rd_cyc = 0;
  logic [31:0] m_addr = '0;
  logic        prev_valid = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  task automatic push_read();
    exp_t e;
    e.addr  = m_addr;
    e.fault = (m_addr >= DEPTH);
    e.instr = e.fault ? NOP : mem_m[m_addr[7:0]];
    e.vcyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Reference model: fetch lifecycle derived from handshake, latency, flush and load rules.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_phase = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (req_valid && !flush && !load_en) begin
             m_addr = req_addr;
             if (WAITC == 0) begin
               push_read();
               m_phase = 2;
             end else begin
               m_rd_cyc = cyc + WAITC;
               m_phase  = 1;
             end
           end
        1: if (flush) m_phase = 0;
           else if (cyc == m_rd_cyc) begin
             push_read();
             m_phase = 2;
           end
        default: if (rsp_ready || flush) begin
                   if (!rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                   m_phase = 0;
                 end
      endcase
    end
    // Write after the read so a same-edge read sees the old word.
    if (load_en) mem_m[load_addr[7:0]] = load_data;
  end

  // Monitor: compares the presented response and handshake signals against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("req_ready", 32'(req_ready), 32'(m_phase == 0 && !flush && !load_en));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
      if (rsp_valid && exp_q.size() > 0) begin
        chk("rsp_instr", rsp_instr, exp_q[0].instr);
        chk("rsp_addr", rsp_addr, exp_q[0].addr);
        chk("rsp_fault", 32'(rsp_fault), 32'(exp_q[0].fault));
        if (!prev_valid) chk("latency", 32'(cyc), 32'(exp_q[0].vcyc));
        if (rsp_ready) void'(exp_q.pop_front());
      end
      prev_valid = rsp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  logic [31:0] old_w, new_w;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_rsp_addr", rsp_addr, 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_addr = 32'(i); load_data = $urandom;
      step();
    end
    load_en = 1'b0;

    // Basic fetch of a loaded word
    load_en = 1'b1; load_addr = 32'd5; load_data = 32'h00A0_0093;
    step();
    load_en = 1'b0; rsp_ready = 1'b1;
    request(32'd5);
    step();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_instr", rsp_instr, 32'h00A0_0093);
    chk("t1_addr", rsp_addr, 32'd5);
    chk("t1_fault", 32'(rsp_fault), 32'd0);
    step();

    // Backpressure with a second request waiting
    rsp_ready = 1'b0;
    request(32'd9);
    req_valid = 1'b1; req_addr = 32'd10;
    step();
    old_w = rsp_instr;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req_ready_low", 32'(req_ready), 32'd0);
      chk("t2_hold_instr", rsp_instr, old_w);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("t2_resume", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    repeat (3) step();

    // Out-of-range fetch
    request(32'd300);
    step();
    chk("t3_instr", rsp_instr, NOP);
    chk("t3_fault", 32'(rsp_fault), 32'd1);
    step();

    // Flush while waiting for data
    request(32'd20);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(rsp_valid), 32'd0);
    request(32'd21);
    step();
    chk("t4_next_valid", 32'(rsp_valid), 32'd1);
    chk("t4_next_instr", rsp_instr, mem_m[21]);
    step();

    // Load to the word being read on the same edge
    old_w = mem_m[7];
    new_w = ~old_w ^ 32'h5A5A_0001;
    request(32'd7);
    load_en = 1'b1; load_addr = 32'd7; load_data = new_w;
    step();
    load_en = 1'b0;
    chk("t5_old_word", rsp_instr, old_w);
    step();
    request(32'd7);
    step();
    chk("t5_new_word", rsp_instr, new_w);
    step();

    // Async reset while a response is held
    rsp_ready = 1'b0;
    request(32'd5);
    step();
    chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(rsp_valid), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_addr", rsp_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; rsp_ready = 1'b1;
    request(32'd5);
    step();
    chk("t6_refetch", rsp_instr, 32'h00A0_0093);
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 9))
        0:       req_addr = 32'd256 + $urandom_range(0, 1000);
        1:       req_addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: req_addr = 32'($urandom_range(0, 255));
      endcase
      load_en   = ($urandom_range(0, 7) == 0);
      load_addr = 32'($urandom_range(0, 255));
      load_data = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0; load_en = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (WAITC + 5) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
